// File: rtl/riscv_branch_pkg.sv
// Shared RISC-V branch constants, counter encoding
// and the saturating 2-bit counter step function.
package riscv_branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    function automatic ctr_t ctr_next(ctr_t c, logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_ST) n = ctr_t'(c + 2'd1);
        end else begin
            if (c != CTR_SNT) n = ctr_t'(c - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_resolve_pht_if.sv
// Fetch-prediction and resolve-stage bundle between
// the pipeline (master) and the predictor (slave).
interface branch_resolve_pht_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] fetch_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic            ex_nop;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            pc_src;
    logic            redirect_taken;
    logic            mispredict;

    modport master (
        output fetch_pc, ex_valid, ex_nop, ex_pc,
        output ex_pred_taken, opcode, funct3,
        output operand1, operand2,
        input  pred_taken, pc_src,
        input  redirect_taken, mispredict
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_nop, ex_pc,
        input  ex_pred_taken, opcode, funct3,
        input  operand1, operand2,
        output pred_taken, pc_src,
        output redirect_taken, mispredict
    );
endinterface

// File: rtl/branch_cmp.sv
// Conditional-branch comparator; opcode-free, reports
// whether funct3 names a real branch condition.
module branch_cmp
    import riscv_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            taken,
    output logic            valid_f3
);

    // funct3 2/3 are reserved: never taken, never valid
    always_comb begin
        taken    = 1'b0;
        valid_f3 = 1'b1;
        unique case (funct3)
            F3_BEQ:  taken = (op_a == op_b);
            F3_BNE:  taken = (op_a != op_b);
            F3_BLT:  taken = ($signed(op_a) < $signed(op_b));
            F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: taken = (op_a < op_b);
            F3_BGEU: taken = (op_a >= op_b);
            default: valid_f3 = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_pht.sv
// Branch resolution plus a PC-indexed table of 2-bit
// saturating counters and branch statistics.
module branch_resolve_pht
    import riscv_branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         PHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    branch_resolve_pht_if.slave bus,
    output logic [STAT_W-1:0]   stat_branches,
    output logic [STAT_W-1:0]   stat_mispredicts
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    ctr_t              pht_q [PHT_DEPTH];
    ctr_t              pht_d [PHT_DEPTH];
    logic [STAT_W-1:0] br_cnt_q;
    logic [STAT_W-1:0] br_cnt_d;
    logic [STAT_W-1:0] mp_cnt_q;
    logic [STAT_W-1:0] mp_cnt_d;

    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic              resolve;
    logic              taken;
    logic              valid_f3;
    logic              counted;
    logic              pc_src;
    logic              redirect_taken;
    logic              mispredict;
    logic              unused_pc;

    assign f_idx   = bus.fetch_pc[IDX_W+1:2];
    assign ex_idx  = bus.ex_pc[IDX_W+1:2];
    assign resolve = bus.ex_valid & ~bus.ex_nop & ~reset;

    assign unused_pc = ^{bus.fetch_pc[XLEN-1:IDX_W+2],
                         bus.fetch_pc[1:0],
                         bus.ex_pc[XLEN-1:IDX_W+2],
                         bus.ex_pc[1:0]};

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .funct3   (bus.funct3),
        .op_a     (bus.operand1),
        .op_b     (bus.operand2),
        .taken    (taken),
        .valid_f3 (valid_f3)
    );

    // Resolve decode: redirect / mispredict / counted
    always_comb begin
        pc_src         = 1'b0;
        redirect_taken = 1'b0;
        mispredict     = 1'b0;
        counted        = 1'b0;
        if (resolve) begin
            unique case (bus.opcode)
                OPC_BRANCH: begin
                    if (valid_f3) begin
                        counted        = 1'b1;
                        mispredict     = taken ^ bus.ex_pred_taken;
                        pc_src         = mispredict;
                        redirect_taken = taken;
                    end
                end
                OPC_JAL, OPC_JALR: begin
                    pc_src         = 1'b1;
                    redirect_taken = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_src         = pc_src;
    assign bus.redirect_taken = redirect_taken;
    assign bus.mispredict     = mispredict;

    // Prediction reads registered state only, no bypass
    assign bus.pred_taken = pht_q[f_idx][1];

    // Next PHT contents: bulk init on reset, else train
    always_comb begin
        for (int i = 0; i < PHT_DEPTH; i++) begin
            pht_d[i] = pht_q[i];
        end
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht_d[i] = ctr_t'(CTR_INIT);
            end
        end else if (counted) begin
            pht_d[ex_idx] = ctr_next(pht_q[ex_idx], taken);
        end
    end

    // Next statistics values, wrapping naturally
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (reset) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else if (counted) begin
            br_cnt_d = br_cnt_q + STAT_W'(1);
            if (mispredict) begin
                mp_cnt_d = mp_cnt_q + STAT_W'(1);
            end
        end
    end

    // State registers; reset handled in the _d logic
    always_ff @(posedge clk) begin
        for (int i = 0; i < PHT_DEPTH; i++) begin
            pht_q[i] <= pht_d[i];
        end
        br_cnt_q <= br_cnt_d;
        mp_cnt_q <= mp_cnt_d;
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_pht.sv
// Directed bench for branch_resolve_pht with a
// scoreboard queue and a small reference model.
module tb_branch_resolve_pht;
    import riscv_branch_pkg::*;

    localparam logic [6:0] OPB = 7'h63;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_resolve_pht_if #(.XLEN(32)) u_if ();
    branch_resolve_pht_if #(.XLEN(32)) u_if4 ();

    logic [31:0] sb;
    logic [31:0] sm;
    logic [31:0] sb4;
    logic [31:0] sm4;

    branch_resolve_pht #(
        .XLEN      (32),
        .PHT_DEPTH (64),
        .CTR_INIT  (2'b01),
        .STAT_W    (32)
    ) u_dut (
        .clk              (clk),
        .reset            (rst),
        .bus              (u_if),
        .stat_branches    (sb),
        .stat_mispredicts (sm)
    );

    branch_resolve_pht #(
        .XLEN      (32),
        .PHT_DEPTH (4),
        .CTR_INIT  (2'b01),
        .STAT_W    (32)
    ) u_dut4 (
        .clk              (clk),
        .reset            (rst),
        .bus              (u_if4),
        .stat_branches    (sb4),
        .stat_mispredicts (sm4)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic        ps;
        logic        rt;
        logic        mp;
        logic        pt;
        logic [31:0] b;
        logic [31:0] m;
    } exp_t;

    exp_t        sbq [$];
    logic [1:0]  m_pht [64];
    logic [31:0] m_b;
    logic [31:0] m_m;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // returns {valid_f3, taken}
    function automatic logic [1:0] ref_br(
        input logic [2:0] f3,
        input logic [31:0] a,
        input logic [31:0] b);
        case (f3)
            3'd0: return {1'b1, a == b};
            3'd1: return {1'b1, a != b};
            3'd4: return {1'b1, $signed(a) < $signed(b)};
            3'd5: return {1'b1, $signed(a) >= $signed(b)};
            3'd6: return {1'b1, a < b};
            3'd7: return {1'b1, a >= b};
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
        m_b = 0;
        m_m = 0;
    endtask

    task automatic step(string tag, logic r, logic v,
                        logic n, logic [31:0] epc,
                        logic ep, logic [6:0] op,
                        logic [2:0] f3, logic [31:0] a,
                        logic [31:0] b, logic [31:0] fpc);
        exp_t       e;
        exp_t       got;
        logic [1:0] bt;
        logic       res;
        logic       cnt;
        logic [5:0] ei;
        @(negedge clk);
        bt  = ref_br(f3, a, b);
        res = v & ~n & ~r;
        cnt = res && (op == OPB) && bt[1];
        e.tag = tag;
        e.ps  = 1'b0;
        e.rt  = 1'b0;
        e.mp  = 1'b0;
        e.pt  = m_pht[fpc[7:2]][1];
        e.b   = m_b;
        e.m   = m_m;
        if (cnt) begin
            e.mp = bt[0] ^ ep;
            e.ps = e.mp;
            e.rt = bt[0];
        end else if (res && (op == 7'h6F || op == 7'h67)) begin
            e.ps = 1'b1;
            e.rt = 1'b1;
        end
        sbq.push_back(e);
        rst                  = r;
        u_if.ex_valid        = v;
        u_if.ex_nop          = n;
        u_if.ex_pc           = epc;
        u_if.ex_pred_taken   = ep;
        u_if.opcode          = op;
        u_if.funct3          = f3;
        u_if.operand1        = a;
        u_if.operand2        = b;
        u_if.fetch_pc        = fpc;
        #2;
        got = sbq.pop_front();
        chk({got.tag, ".pc_src"}, 32'(u_if.pc_src), 32'(got.ps));
        chk({got.tag, ".redir"},
            32'(u_if.redirect_taken), 32'(got.rt));
        chk({got.tag, ".misp"}, 32'(u_if.mispredict), 32'(got.mp));
        chk({got.tag, ".pred"}, 32'(u_if.pred_taken), 32'(got.pt));
        chk({got.tag, ".sb"}, sb, got.b);
        chk({got.tag, ".sm"}, sm, got.m);
        if (r) begin
            model_reset();
        end else if (cnt) begin
            ei = epc[7:2];
            if (bt[0] && m_pht[ei] != 2'b11) m_pht[ei]++;
            if (!bt[0] && m_pht[ei] != 2'b00) m_pht[ei]--;
            m_b++;
            if (bt[0] ^ ep) m_m++;
        end
    endtask

    task automatic idle(string tag, logic [31:0] fpc);
        step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 7'h0,
             3'd0, 32'h0, 32'h0, fpc);
    endtask

    initial begin
        rst = 1'b1;
        u_if.ex_valid = 0; u_if.ex_nop = 0; u_if.ex_pc = 0;
        u_if.ex_pred_taken = 0; u_if.opcode = 0;
        u_if.funct3 = 0; u_if.operand1 = 0;
        u_if.operand2 = 0; u_if.fetch_pc = 0;
        u_if4.ex_valid = 0; u_if4.ex_nop = 0; u_if4.ex_pc = 0;
        u_if4.ex_pred_taken = 0; u_if4.opcode = 0;
        u_if4.funct3 = 0; u_if4.operand1 = 0;
        u_if4.operand2 = 0; u_if4.fetch_pc = 0;
        model_reset();
        repeat (2) @(posedge clk);

        idle("rst_100", 32'h100);
        chk("rst_pred_const", 32'(u_if.pred_taken), 32'd0);
        chk("rst_sb_const", sb, 32'd0);
        idle("rst_0", 32'h0);
        idle("rst_fc", 32'hFC);

        step("beq_mp", 0, 1, 0, 32'h100, 0, OPB, 3'd0,
             32'd5, 32'd5, 32'h100);
        chk("beq_mp_const", 32'(u_if.mispredict), 32'd1);
        idle("after_beq", 32'h100);
        chk("beq_pred_const", 32'(u_if.pred_taken), 32'd1);
        chk("beq_sm_const", sm, 32'd1);

        for (int i = 0; i < 4; i++) begin
            step("bge", 0, 1, 0, 32'h40, 1, OPB, 3'd5,
                 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h40);
        end
        step("bltu", 0, 1, 0, 32'h40, 1, OPB, 3'd6,
             32'hFFFF_FFFF, 32'd1, 32'h40);
        idle("after_bltu", 32'h40);
        chk("bltu_pred_const", 32'(u_if.pred_taken), 32'd1);
        step("bltu2", 0, 1, 0, 32'h40, 1, OPB, 3'd6,
             32'hFFFF_FFFF, 32'd1, 32'h40);
        idle("after_bltu2", 32'h40);
        chk("sat_pred_const", 32'(u_if.pred_taken), 32'd0);

        step("jalr_nop", 0, 1, 1, 32'h80, 0, 7'h67, 3'd0,
             32'd0, 32'd0, 32'h0);
        step("jalr", 0, 1, 0, 32'h80, 0, 7'h67, 3'd0,
             32'd0, 32'd0, 32'h0);
        chk("jalr_src_const", 32'(u_if.pc_src), 32'd1);
        step("jal", 0, 1, 0, 32'h84, 1, 7'h6F, 3'd0,
             32'd0, 32'd0, 32'h0);

        step("f3_2", 0, 1, 0, 32'h100, 0, OPB, 3'd2,
             32'd7, 32'd7, 32'h100);
        step("f3_3", 0, 1, 0, 32'h100, 0, OPB, 3'd3,
             32'd1, 32'd9, 32'h100);
        step("alu_op", 0, 1, 0, 32'h100, 0, 7'h33, 3'd0,
             32'd7, 32'd7, 32'h100);
        step("no_valid", 0, 0, 0, 32'h100, 0, OPB, 3'd0,
             32'd3, 32'd4, 32'h100);
        idle("after_f3", 32'h100);

        step("bne", 0, 1, 0, 32'h20, 0, OPB, 3'd1,
             32'd1, 32'd2, 32'h20);
        step("blt", 0, 1, 0, 32'h24, 1, OPB, 3'd4,
             32'hFFFF_FFFB, 32'd3, 32'h24);
        step("bgeu", 0, 1, 1, 32'h28, 1, OPB, 3'd7,
             32'd3, 32'h8000_0000, 32'h28);
        step("beq_nt", 0, 1, 0, 32'h2C, 0, OPB, 3'd0,
             32'd3, 32'd4, 32'h20);

        step("rw_same", 0, 1, 0, 32'h60, 0, OPB, 3'd0,
             32'd1, 32'd1, 32'h60);
        chk("rw_pre_const", 32'(u_if.pred_taken), 32'd0);
        idle("rw_after", 32'h60);
        chk("rw_post_const", 32'(u_if.pred_taken), 32'd1);

        step("rst_mp", 1, 1, 0, 32'h100, 0, OPB, 3'd0,
             32'd5, 32'd5, 32'h100);
        idle("post_rst_100", 32'h100);
        chk("post_rst_sm", sm, 32'd0);
        idle("post_rst_40", 32'h40);
        idle("post_rst_60", 32'h60);

        @(negedge clk);
        u_if4.ex_valid = 1; u_if4.ex_pc = 32'h0;
        u_if4.ex_pred_taken = 0; u_if4.opcode = OPB;
        u_if4.funct3 = 3'd0; u_if4.operand1 = 32'd9;
        u_if4.operand2 = 32'd9; u_if4.fetch_pc = 32'h10;
        #2;
        chk("al_pred0", 32'(u_if4.pred_taken), 32'd0);
        chk("al_misp0", 32'(u_if4.mispredict), 32'd1);
        @(negedge clk);
        u_if4.ex_valid = 0; u_if4.fetch_pc = 32'h10;
        #2;
        chk("al_pred10", 32'(u_if4.pred_taken), 32'd1);
        chk("al_sb1", sb4, 32'd1);
        @(negedge clk);
        u_if4.ex_valid = 1; u_if4.ex_pc = 32'h10;
        u_if4.ex_pred_taken = 1; u_if4.funct3 = 3'd1;
        u_if4.fetch_pc = 32'h0;
        #2;
        chk("al_misp1", 32'(u_if4.mispredict), 32'd1);
        chk("al_pre0", 32'(u_if4.pred_taken), 32'd1);
        @(negedge clk);
        u_if4.ex_valid = 0; u_if4.fetch_pc = 32'h0;
        #2;
        chk("al_post0", 32'(u_if4.pred_taken), 32'd0);
        chk("al_sb2", sb4, 32'd2);
        chk("al_sm2", sm4, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_pht.md
BRANCH_RESOLVE_PHT -- requirements
Module: branch_resolve_pht

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and PC width.
REQ-002 SHALL have parameter PHT_DEPTH, default 64, number of 2-bit counters; power of two, 4..1024.
REQ-003 SHALL have parameter CTR_INIT, default 2'b01, counter reset value (weakly not-taken).
REQ-004 SHALL have parameter STAT_W, default 32, statistics counter width.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 fetch_pc  in  XLEN  PC of instruction being fetched.
REQ-008 pred_taken  out  1  prediction for fetch_pc, combinational.
REQ-009 ex_valid  in  1  resolve-stage instruction valid.
REQ-010 ex_nop  in  1  resolve-stage bubble/flushed; suppresses all resolve effects.
REQ-011 ex_pc  in  XLEN  PC of resolving instruction.
REQ-012 ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
REQ-013 opcode  in  7  resolving instruction opcode.
REQ-014 funct3  in  3  resolving instruction funct3.
REQ-015 operand1, operand2  in  XLEN each  rs1/rs2 values.
REQ-016 pc_src  out  1  redirect fetch this cycle.
REQ-017 redirect_taken  out  1  on redirect: 1 = go to target, 0 = go to ex_pc+4.
REQ-018 mispredict  out  1  conditional branch outcome differed from ex_pred_taken.
REQ-019 stat_branches, stat_mispredicts  out  STAT_W each  resolved-branch and mispredict counts.

Function
REQ-020 Index idx(pc) SHALL be pc[log2(PHT_DEPTH)+1:2]; pred_taken SHALL equal bit 1 of counter[idx(fetch_pc)].
REQ-021 resolve = ex_valid & ~ex_nop & ~reset; with resolve low, pc_src, redirect_taken, mispredict SHALL be 0.
REQ-022 Branch (opcode 0x63) outcome by funct3: 0 eq, 1 ne, 4 signed lt, 5 signed ge, 6 unsigned lt, 7 unsigned ge; funct3 2/3 SHALL be treated as not-taken, no PHT update, not counted.
REQ-023 For a counted branch: mispredict = taken XOR ex_pred_taken; pc_src = mispredict; redirect_taken = taken; all combinational, same cycle.
REQ-024 jal (0x6F) and jalr (0x67) SHALL drive pc_src=1, redirect_taken=1, mispredict=0, no PHT update, not counted.
REQ-025 Any other opcode SHALL drive all three outputs 0.
REQ-026 At the clock edge of a counted branch, counter[idx(ex_pc)] SHALL increment if taken, decrement if not, saturating at 3 and 0.
REQ-027 Same-cycle fetch read and resolve write to one index: pred_taken SHALL reflect the pre-update value (no bypass).
REQ-028 stat_branches SHALL increment per counted branch; stat_mispredicts per counted mispredict; both wrap modulo 2^STAT_W.
REQ-029 Update latency one cycle: next-cycle pred_taken for that index SHALL reflect the new counter.

Reset
REQ-030 On reset, all PHT_DEPTH counters SHALL load CTR_INIT in that single cycle; stat counters SHALL load 0.
REQ-031 Reset SHALL dominate a simultaneous resolve: no counter or stat update that cycle; outputs of REQ-021 held 0.
REQ-032 After reset deasserts, pred_taken SHALL equal CTR_INIT[1] for every PC.

Structure
REQ-033 Opcode and funct3 constants and the 2-bit counter encoding SHALL live in shared package riscv_branch_pkg.
REQ-034 Branch comparison (REQ-022) SHALL be sub-module branch_cmp (opcode-free: funct3, operands -> taken, valid_f3).
REQ-035 The PHT SHALL be a flop array, no memory macro; no latches, no negedge logic.

Verification
REQ-036 Reset, then fetch_pc=0x100 -> pred_taken=0; stat counters 0.
REQ-037 Resolve beq at ex_pc=0x100, operands 5/5, ex_pred_taken=0 -> pc_src=1, redirect_taken=1, mispredict=1; next cycle counter=2, pred_taken=1, stat_mispredicts=1.
REQ-038 Four taken bges at 0x40 (-1 vs -2) then bltu 0x40 (0xFFFFFFFF vs 1, not taken) -> counter saturates at 3, then 2; pred_taken stays 1.
REQ-039 jalr with ex_nop=1 -> all outputs 0; with ex_nop=0 -> pc_src=1, redirect_taken=1, stats unchanged.
REQ-040 funct3=2 branch -> outputs 0, no update; reset asserted concurrently with a counted mispredict -> no stat change, counters CTR_INIT.
REQ-041 PHT_DEPTH=4: branches at 0x0 and 0x10 alias to index 0 -> shared counter updates observed.
